mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the MIPS pipeline IF stage (instruction fetch)
//  and MEM stage (lw/sw). Each access takes a fixed number of cycles; the stall the pipeline
//  must honour is driven towards each requester. Sits between if_stage/mem_stage and the
//  memory macro inside mips. MEM has priority, with a starvation guard for IF.
// PARAMETERS
//  AW          32  address width (byte address, passed unchanged to memory)
//  DW          32  data width
//  MEM_LAT     2   cycles from m_en pulse to m_rdata valid; legal range 1..15
//  MAX_STREAK  3   max consecutive data grants while if_req pending before IF is forced
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   IF read request; held high until if_valid
//  if_addr    in   AW  IF fetch address; stable while if_req
//  if_valid   out  1   1-cycle pulse: if_rdata valid, IF request retired
//  if_rdata   out  DW  fetched instruction word
//  if_stall   out  1   if_req & ~if_valid (combinational)
//  d_req      in   1   MEM request; held high until d_valid
//  d_we       in   1   1=store (sw), 0=load (lw)
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_valid    out  1   1-cycle pulse: load data valid / store committed
//  d_rdata    out  DW  load data
//  d_stall    out  1   d_req & ~d_valid (combinational)
//  m_en       out  1   1-cycle memory access strobe
//  m_we       out  1   write enable, qualified by m_en
//  m_addr     out  AW  memory address (registered, held for whole access)
//  m_wdata    out  DW  memory write data (registered)
//  m_rdata    in   DW  memory read data, valid MEM_LAT cycles after m_en
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, counter 0, streak 0; all outputs 0 except the
//   combinational stalls, which follow the req inputs. Reset mid-access aborts it: no valid pulse.
//  FSM states IDLE, BUSY_IF, BUSY_D.
//  IDLE, arbitration each cycle:
//   d_req & !(if_req & streak==MAX_STREAK) -> grant D; else if_req -> grant IF; else stay.
//   On grant: register addr/wdata/we into m_*, pulse m_en for 1 cycle, counter<=0, enter BUSY_x.
//  BUSY_x: counter increments each cycle; when counter==MEM_LAT-1, capture m_rdata into x_rdata,
//   pulse x_valid for that cycle, return to IDLE. Next grant earliest the following cycle.
//   Access cost = MEM_LAT+1 cycles from grant to next possible grant.
//  Stores: d_valid pulses at the same point; d_rdata holds its previous value.
//  x_rdata holds its last captured value until the next completion of the same requester.
//  Streak: +1 on each D grant issued while if_req=1 (saturates at MAX_STREAK); cleared on IF
//   grant or any cycle with if_req=0.
//  Request dropped mid-access: access still completes and valid still pulses (requester ignores it).
//  New req asserted during BUSY: waits; no request is ever lost or served twice.
//  m_addr/m_wdata/m_we hold their last value while IDLE; m_en=0 except on grant cycles.
// STRUCTURE
//  Package mips_mem_pkg: arb_state_t enum {IDLE, BUSY_IF, BUSY_D}, LAT_W=4 counter width,
//   default AW/DW constants shared with mem_stage.
//  Sub-module mem_lat_counter (load/clear, terminal-count flag at MEM_LAT-1); rest is flat.
// TESTING
//  1 IF only, if_addr=0x04, mem[0x04]=0x20010005, MEM_LAT=2 -> m_en at grant t0, if_valid
//    and if_rdata=0x20010005 at t0+2; if_stall high t0..t0+1 only.
//  2 Simultaneous if_req and d_req (lw 0x64, mem=7) -> D granted first, d_rdata=7; IF granted
//    the cycle after d_valid.
//  3 d_req held continuously (4 back-to-back lw) with if_req high, MAX_STREAK=3 -> grant order
//    D,D,D,IF,D; never a 4th consecutive D while IF waits.
//  4 sw d_addr=0x68 d_wdata=0xDEAD -> m_we=1 with m_en, d_valid pulses, d_rdata unchanged;
//    a following lw 0x68 returns 0xDEAD.
//  5 reset driven low one cycle after an IF grant -> no if_valid, state IDLE, streak 0; after
//    release the still-held if_req is re-granted and completes normally.
//  6 MEM_LAT=1 build, alternating IF/D requests -> valid 1 cycle after each grant; one access
//    per 2 cycles; scoreboard matches every returned word against the memory model.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter and the
// pipeline stages that talk to it.
package mips_mem_pkg;

    localparam int DEF_AW = 32;  // byte address width used by if_stage/mem_stage
    localparam int DEF_DW = 32;  // memory word width
    localparam int LAT_W  = 4;   // latency counter width, covers MEM_LAT up to 15

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF-stage, MEM-stage and memory-macro signals around the
// arbiter. The arbiter takes the slave view; the surrounding pipeline and
// memory take the master view.
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    // instruction fetch side
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    // load/store side
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          d_stall;
    // memory macro side
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_valid, if_rdata, if_stall, d_valid, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_valid, if_rdata, if_stall, d_valid, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_counter.sv
// Access latency counter: cleared on a grant, counts while an access is in
// flight, and flags the cycle in which the memory read data is valid.
module mem_lat_counter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [LAT_W-1:0] count_q;

    // Cycle counter; it never passes MEM_LAT because the FSM leaves BUSY at tc.
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = (count_q == LAT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Load/store wins arbitration unless it has already taken MAX_STREAK grants in
// a row while a fetch was waiting. The new access is presented to the memory
// in the grant cycle and held in registers for the rest of the access.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    arb_state_t          state_q, state_d;
    logic                grant_if, grant_d;
    logic                if_done, d_done, load_done;
    logic                tc;
    logic                force_if;
    logic [STREAK_W-1:0] streak_q;
    logic [AW-1:0]       m_addr_q;
    logic [DW-1:0]       m_wdata_q;
    logic                m_we_q;
    logic [DW-1:0]       if_rdata_q, d_rdata_q;

    mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk   (clk),
        .reset (reset),
        .clear (grant_if | grant_d),
        .inc   (state_q != IDLE),
        .tc    (tc)
    );

    // IF must win once data has taken MAX_STREAK consecutive grants past it.
    assign force_if = bus.if_req && (streak_q == STREAK_W'(MAX_STREAK));

    // Arbitration, completion detection and next state.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if_done  = 1'b0;
        d_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // no grant while reset is held, so m_en stays low in reset
                if (reset) begin
                    if (bus.d_req && !force_if) begin
                        grant_d = 1'b1;
                        state_d = BUSY_D;
                    end else if (bus.if_req) begin
                        grant_if = 1'b1;
                        state_d  = BUSY_IF;
                    end
                end
            end
            BUSY_IF: begin
                if (tc) begin
                    if_done = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (tc) begin
                    d_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; an async reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Consecutive data grants taken while a fetch was waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else if (!bus.if_req || grant_if) begin
            streak_q <= '0;
        end else if (grant_d && streak_q != STREAK_W'(MAX_STREAK)) begin
            streak_q <= streak_q + 1'b1;
        end
    end

    // Latch the granted request so the memory sees it for the whole access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
        end else if (grant_d) begin
            m_addr_q  <= bus.d_addr;
            m_wdata_q <= bus.d_wdata;
            m_we_q    <= bus.d_we;
        end else if (grant_if) begin
            m_addr_q  <= bus.if_addr;
            m_we_q    <= 1'b0;
        end
    end

    // Keep the last word returned to each requester.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_done) begin
                if_rdata_q <= bus.m_rdata;
            end
            if (load_done) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

    // Stores complete without touching d_rdata.
    assign load_done = d_done && !m_we_q;

    // In the grant cycle the new request bypasses the registers so the memory
    // samples it together with m_en; afterwards the registered copy holds it.
    assign bus.m_en    = grant_if | grant_d;
    assign bus.m_addr  = grant_d ? bus.d_addr  : (grant_if ? bus.if_addr : m_addr_q);
    assign bus.m_wdata = grant_d ? bus.d_wdata : m_wdata_q;
    assign bus.m_we    = grant_d ? bus.d_we    : (grant_if ? 1'b0 : m_we_q);

    assign bus.if_valid = if_done;
    assign bus.d_valid  = d_done;
    assign bus.if_rdata = if_done   ? bus.m_rdata : if_rdata_q;
    assign bus.d_rdata  = load_done ? bus.m_rdata : d_rdata_q;
    assign bus.if_stall = bus.if_req & ~if_done;
    assign bus.d_stall  = bus.d_req  & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut0 built with MEM_LAT=2, dut1 with
// MEM_LAT=1. Directed stimulus pushes expected grants and returned words into
// queues; a negedge monitor pops and compares whenever the DUTs present them.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          is_if;
    } grant_t;

    typedef struct {
        logic        rst, m_en, m_we, if_req, if_valid, if_stall, d_req, d_valid, d_stall;
        logic [31:0] m_addr, m_wdata, if_rdata, d_rdata;
    } snap_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();

    mem_port_arbiter #(.MEM_LAT(LAT0), .MAX_STREAK(3)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
    mem_port_arbiter #(.MEM_LAT(LAT1), .MAX_STREAK(3)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

    // ---------------- memory models ----------------
    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h04:  return 32'h20010005;
            32'h08:  return 32'h8C020064;
            32'h64:  return 32'h00000007;
            32'h70:  return 32'h00000011;
            32'h74:  return 32'h00000022;
            32'h78:  return 32'h00000033;
            32'h7C:  return 32'h00000044;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    logic [31:0] wmem0 [256];
    logic [31:0] wmem1 [256];
    bit   [255:0] wr0, wr1;
    logic [31:0] p0 [LAT0];
    logic [31:0] p1 [LAT1];

    always @(posedge clk) begin
        if (b0.m_en) begin
            if (b0.m_we) begin
                wmem0[b0.m_addr[9:2]] <= b0.m_wdata;
                wr0[b0.m_addr[9:2]]   <= 1'b1;
            end
            p0[0] <= wr0[b0.m_addr[9:2]] ? wmem0[b0.m_addr[9:2]] : init_val(b0.m_addr);
        end else begin
            p0[0] <= 32'hBADC0FFE;
        end
        for (int k = 1; k < LAT0; k++) p0[k] <= p0[k-1];
    end
    assign b0.m_rdata = p0[LAT0-1];

    always @(posedge clk) begin
        if (b1.m_en) begin
            if (b1.m_we) begin
                wmem1[b1.m_addr[9:2]] <= b1.m_wdata;
                wr1[b1.m_addr[9:2]]   <= 1'b1;
            end
            p1[0] <= wr1[b1.m_addr[9:2]] ? wmem1[b1.m_addr[9:2]] : init_val(b1.m_addr);
        end else begin
            p1[0] <= 32'hBADC0FFE;
        end
        for (int k = 1; k < LAT1; k++) p1[k] <= p1[k-1];
    end
    assign b1.m_rdata = p1[LAT1-1];

    // ---------------- scoreboard ----------------
    grant_t      g_q0 [$];
    grant_t      g_q1 [$];
    logic [31:0] if_q0 [$];
    logic [31:0] if_q1 [$];
    logic [31:0] d_q0 [$];
    logic [31:0] d_q1 [$];

    int cyc [2];
    int last_grant [2];
    bit have_grant [2];
    int last_if_grant [2];
    int last_d_valid [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%08h with nothing expected (t=%0t)", name, act, $time);
    endtask

    task automatic exp_grant(input int u, input logic [31:0] a, input logic we,
                             input logic [31:0] wd, input bit is_if);
        grant_t g;
        g = '{addr: a, we: we, wdata: wd, is_if: is_if};
        if (u == 0) g_q0.push_back(g);
        else        g_q1.push_back(g);
    endtask

    task automatic exp_word(input int u, input bit is_d, input logic [31:0] v);
        if (u == 0) begin
            if (is_d) d_q0.push_back(v); else if_q0.push_back(v);
        end else begin
            if (is_d) d_q1.push_back(v); else if_q1.push_back(v);
        end
    endtask

    function automatic bit pop_grant(input int u, output grant_t g);
        if (u == 0) begin
            if (g_q0.size() == 0) return 1'b0;
            g = g_q0.pop_front();
        end else begin
            if (g_q1.size() == 0) return 1'b0;
            g = g_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_word(input int u, input bit is_d, output logic [31:0] v);
        if (u == 0 && is_d) begin
            if (d_q0.size() == 0) return 1'b0;
            v = d_q0.pop_front();
        end else if (u == 0) begin
            if (if_q0.size() == 0) return 1'b0;
            v = if_q0.pop_front();
        end else if (is_d) begin
            if (d_q1.size() == 0) return 1'b0;
            v = d_q1.pop_front();
        end else begin
            if (if_q1.size() == 0) return 1'b0;
            v = if_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic snap_t snap(input int u);
        snap_t s;
        if (u == 0) begin
            s = '{rst: rst0, m_en: b0.m_en, m_we: b0.m_we, if_req: b0.if_req,
                  if_valid: b0.if_valid, if_stall: b0.if_stall, d_req: b0.d_req,
                  d_valid: b0.d_valid, d_stall: b0.d_stall, m_addr: b0.m_addr,
                  m_wdata: b0.m_wdata, if_rdata: b0.if_rdata, d_rdata: b0.d_rdata};
        end else begin
            s = '{rst: rst1, m_en: b1.m_en, m_we: b1.m_we, if_req: b1.if_req,
                  if_valid: b1.if_valid, if_stall: b1.if_stall, d_req: b1.d_req,
                  d_valid: b1.d_valid, d_stall: b1.d_stall, m_addr: b1.m_addr,
                  m_wdata: b1.m_wdata, if_rdata: b1.if_rdata, d_rdata: b1.d_rdata};
        end
        return s;
    endfunction

    task automatic mon_step(input int u);
        snap_t       s;
        grant_t      g;
        logic [31:0] v;
        int          lat;
        s   = snap(u);
        lat = (u == 0) ? LAT0 : LAT1;
        cyc[u]++;
        if (!s.rst) begin
            have_grant[u] = 1'b0;
            check("reset_m_en", 32'(s.m_en), 32'd0);
            check("reset_if_valid", 32'(s.if_valid), 32'd0);
            check("reset_d_valid", 32'(s.d_valid), 32'd0);
            check("reset_if_rdata", s.if_rdata, 32'd0);
            check("reset_d_rdata", s.d_rdata, 32'd0);
            check("reset_m_addr", s.m_addr, 32'd0);
        end else begin
            if (s.m_en) begin
                if (!pop_grant(u, g)) begin
                    fail_now("grant_unexpected", s.m_addr);
                end else begin
                    check("grant_addr", s.m_addr, g.addr);
                    check("grant_we", 32'(s.m_we), 32'(g.we));
                    if (g.we) check("grant_wdata", s.m_wdata, g.wdata);
                    if (have_grant[u]) begin
                        if (u == 0) check("grant_gap_ok", 32'(cyc[u] - last_grant[u] >= lat + 1), 32'd1);
                        else        check("grant_gap", 32'(cyc[u] - last_grant[u]), 32'(lat + 1));
                    end
                    if (g.is_if) last_if_grant[u] = cyc[u];
                end
                have_grant[u] = 1'b1;
                last_grant[u] = cyc[u];
            end
            if (s.if_valid) begin
                if (!pop_word(u, 1'b0, v)) fail_now("if_valid_unexpected", s.if_rdata);
                else check("if_rdata", s.if_rdata, v);
                check("if_latency", 32'(cyc[u] - last_grant[u]), 32'(lat));
            end
            if (s.d_valid) begin
                if (!pop_word(u, 1'b1, v)) fail_now("d_valid_unexpected", s.d_rdata);
                else check("d_rdata", s.d_rdata, v);
                check("d_latency", 32'(cyc[u] - last_grant[u]), 32'(lat));
                last_d_valid[u] = cyc[u];
            end
        end
        check("if_stall", 32'(s.if_stall), 32'(s.if_req & ~s.if_valid));
        check("d_stall", 32'(s.d_stall), 32'(s.d_req & ~s.d_valid));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0);
            mon_step(1);
        end
    end

    // ---------------- requester drivers ----------------
    task automatic if_access(input int u, input logic [31:0] a);
        int n;
        if (u == 0) begin b0.if_addr = a; b0.if_req = 1'b1; end
        else        begin b1.if_addr = a; b1.if_req = 1'b1; end
        n = 0;
        forever begin
            @(negedge clk);
            if ((u == 0) ? b0.if_valid : b1.if_valid) break;
            n++;
            if (n > 40) begin fail_now("if_timeout", a); break; end
        end
        @(posedge clk);
        #1;
        if (u == 0) b0.if_req = 1'b0;
        else        b1.if_req = 1'b0;
    endtask

    task automatic d_access(input int u, input logic we, input logic [31:0] a, input logic [31:0] wd);
        int n;
        if (u == 0) begin b0.d_we = we; b0.d_addr = a; b0.d_wdata = wd; b0.d_req = 1'b1; end
        else        begin b1.d_we = we; b1.d_addr = a; b1.d_wdata = wd; b1.d_req = 1'b1; end
        n = 0;
        forever begin
            @(negedge clk);
            if ((u == 0) ? b0.d_valid : b1.d_valid) break;
            n++;
            if (n > 40) begin fail_now("d_timeout", a); break; end
        end
        @(posedge clk);
        #1;
        if (u == 0) b0.d_req = 1'b0;
        else        b1.d_req = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    logic [31:0] t6_if_a [4] = '{32'h100, 32'h108, 32'h110, 32'h118};
    logic [31:0] t6_d_a  [4] = '{32'h104, 32'h10C, 32'h114, 32'h11C};
    logic [31:0] t6_if_v [4] = '{32'hC0DE0100, 32'hC0DE0108, 32'hC0DE0110, 32'hC0DE0118};
    logic [31:0] t6_d_v  [4] = '{32'hC0DE0104, 32'hC0DE010C, 32'hC0DE0114, 32'hC0DE011C};

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        b0.if_req = 1'b0; b0.if_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(posedge clk);
        #1;

        // 1: lone fetch, word returned two cycles after the grant
        exp_grant(0, 32'h04, 1'b0, 32'h0, 1'b1);
        exp_word(0, 1'b0, 32'h20010005);
        if_access(0, 32'h04);

        // 2: simultaneous requests, data first, fetch the cycle after d_valid
        exp_grant(0, 32'h64, 1'b0, 32'h0, 1'b0);
        exp_grant(0, 32'h08, 1'b0, 32'h0, 1'b1);
        exp_word(0, 1'b1, 32'h00000007);
        exp_word(0, 1'b0, 32'h8C020064);
        fork
            if_access(0, 32'h08);
            d_access(0, 1'b0, 32'h64, 32'h0);
        join
        check("t2_if_after_d_valid", 32'(last_if_grant[0]), 32'(last_d_valid[0] + 1));

        // 3: streak guard, order D,D,D,IF,D
        exp_grant(0, 32'h70, 1'b0, 32'h0, 1'b0);
        exp_grant(0, 32'h74, 1'b0, 32'h0, 1'b0);
        exp_grant(0, 32'h78, 1'b0, 32'h0, 1'b0);
        exp_grant(0, 32'h0C, 1'b0, 32'h0, 1'b1);
        exp_grant(0, 32'h7C, 1'b0, 32'h0, 1'b0);
        exp_word(0, 1'b1, 32'h11);
        exp_word(0, 1'b1, 32'h22);
        exp_word(0, 1'b1, 32'h33);
        exp_word(0, 1'b1, 32'h44);
        exp_word(0, 1'b0, 32'hC0DE000C);
        fork
            begin
                d_access(0, 1'b0, 32'h70, 32'h0);
                d_access(0, 1'b0, 32'h74, 32'h0);
                d_access(0, 1'b0, 32'h78, 32'h0);
                d_access(0, 1'b0, 32'h7C, 32'h0);
            end
            if_access(0, 32'h0C);
        join

        // 4: store leaves d_rdata at the last load value, then read it back
        exp_grant(0, 32'h68, 1'b1, 32'h0000DEAD, 1'b0);
        exp_word(0, 1'b1, 32'h44);
        d_access(0, 1'b1, 32'h68, 32'h0000DEAD);
        exp_grant(0, 32'h68, 1'b0, 32'h0, 1'b0);
        exp_word(0, 1'b1, 32'h0000DEAD);
        d_access(0, 1'b0, 32'h68, 32'h0);

        // 5: reset one cycle after a fetch grant aborts it; fetch re-granted after release
        exp_grant(0, 32'h10, 1'b0, 32'h0, 1'b1);
        exp_grant(0, 32'h10, 1'b0, 32'h0, 1'b1);
        exp_word(0, 1'b0, 32'hC0DE0010);
        fork
            if_access(0, 32'h10);
            begin
                int n;
                n = 0;
                forever begin
                    @(negedge clk);
                    if (b0.m_en) break;
                    n++;
                    if (n > 40) begin fail_now("t5_grant_timeout", 32'h10); break; end
                end
                @(posedge clk);
                #1;
                rst0 = 1'b0;
                @(posedge clk);
                #1;
                rst0 = 1'b1;
            end
        join

        // 6: single-cycle latency build, alternating D/IF one access per 2 cycles
        for (int r = 0; r < 4; r++) begin
            exp_grant(1, t6_d_a[r], 1'b0, 32'h0, 1'b0);
            exp_grant(1, t6_if_a[r], 1'b0, 32'h0, 1'b1);
            exp_word(1, 1'b1, t6_d_v[r]);
            exp_word(1, 1'b0, t6_if_v[r]);
            fork
                if_access(1, t6_if_a[r]);
                d_access(1, 1'b0, t6_d_a[r], 32'h0);
            join
        end

        repeat (4) @(posedge clk);
        #1;
        check("drain_grants0", 32'(g_q0.size()), 32'd0);
        check("drain_grants1", 32'(g_q1.size()), 32'd0);
        check("drain_if0", 32'(if_q0.size()), 32'd0);
        check("drain_d0", 32'(d_q0.size()), 32'd0);
        check("drain_if1", 32'(if_q1.size()), 32'd0);
        check("drain_d1", 32'(d_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
